sd_dev_cmd_phy: RTL and testbench
=================================

Name: sd_dev_cmd_phy

Overview:
- Command-line serializer/deserializer for the SD device stack.
- Sits directly downstream of the device platform block.
  - Consumes its sampled CMD line and its per-bit timing.
  - Drives its CMD output and CMD direction inputs.
- Receives 48-bit host commands: start-bit detection, shifting, CRC7 check, framing check.
- Presents index and argument to the command layer.
- Transmits 48-bit responses (R1/R3/R6/R7 format) after a programmable Ncr gap.

Parameters:
RSP_GAP, 2, number of bit periods between response acceptance and the response start bit (Ncr); legal range 1..15

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous active-high reset
i_bit_en  input  1  one-clk pulse per SD bit period; all line sampling and driving advances only on cycles where it is high
i_sd_cmd_in  input  1  sampled CMD line from the platform block
o_sd_cmd_dir  output  1  1 = device drives CMD
o_sd_cmd_out  output  1  CMD value driven when dir=1
o_cmd_stb  output  1  one-clk pulse: a complete command was received
o_cmd_index  output  6  command index, valid from o_cmd_stb until the next o_cmd_stb
o_cmd_arg  output  32  command argument, same validity as o_cmd_index
o_cmd_crc_err  output  1  qualifies o_cmd_stb: CRC7 mismatch or end bit = 0
i_rsp_stb  input  1  request to send a response; accepted only while o_rsp_busy=0
i_rsp_index  input  6  response index field (R2/R3 callers pass 6'h3F)
i_rsp_arg  input  32  response 32-bit payload
i_rsp_no_crc  input  1  1 = CRC field sent as 7'h7F (R3)
o_rsp_busy  output  1  high while receiving (after start bit), in gap, or transmitting
o_rsp_done  output  1  one-clk pulse after the response end bit has been driven and the line released

Behaviour:
- Reset values:
  - o_sd_cmd_dir=0, o_sd_cmd_out=1
  - o_cmd_stb=0, o_cmd_index=0, o_cmd_arg=0, o_cmd_crc_err=0
  - o_rsp_busy=0, o_rsp_done=0
  - State IDLE, all counters 0.
- rst mid-operation:
  - Takes effect on the next clk edge.
  - dir drops to 0 immediately.
  - Any partial frame is discarded with no o_cmd_stb and no o_rsp_done.
- State IDLE:
  - On i_rsp_stb: latch index/arg/no_crc, go to GAP. This has priority over a start bit seen in the same cycle.
  - Otherwise, on i_bit_en with i_sd_cmd_in=0: go to RX_DIR.
- State RX_DIR: on the next i_bit_en, sample the transmission bit.
  - 1 → RX, bit counter = 0.
  - 0 → IDLE silently: framing abort, no strobe.
- State RX: shift in 46 bits MSB-first on each i_bit_en (6 index, 32 arg, 7 CRC, 1 end).
  - CRC7 (poly x^7+x^3+1, init 0) is computed serially over the first 40 frame bits: start, transmission, index, arg.
  - After the end bit is sampled, on the following clk:
    - o_cmd_stb=1 for exactly one clk.
    - o_cmd_index/o_cmd_arg updated.
    - o_cmd_crc_err = (rx_crc != calc_crc) | (end bit == 0).
    - Return to IDLE.
- Back-to-back commands: a start bit on the i_bit_en immediately after the end bit is accepted.
- i_rsp_stb while o_rsp_busy=1 is ignored; no queuing.
- State GAP:
  - dir=0, cmd_out=1.
  - Count RSP_GAP i_bit_en pulses, then go to TX.
  - CMD line sampling is suspended in GAP, TX and TX_END.
- State TX: on each i_bit_en drive the next bit of {1'b0, 1'b0, index, arg, crc, 1'b1}, MSB-first, with dir=1.
  - 48 bits total.
  - dir and the first bit assert together on the first i_bit_en in TX.
  - crc is CRC7 of the first 40 bits, or 7'h7F when i_rsp_no_crc=1.
- State TX_END:
  - On the next i_bit_en after the end bit: dir=0, cmd_out=1.
  - o_rsp_done pulses one clk, return to IDLE.
- o_rsp_busy is high in RX_DIR, RX, GAP, TX and TX_END.
- Latencies:
  - Command: o_cmd_stb occurs 1 clk after the i_bit_en that samples the end bit.
  - Response: the first driven bit occurs on the (RSP_GAP+1)th i_bit_en after acceptance.

Test Plan:
1. CMD0: host shifts 48'h40_0000_0000_95 at one bit per i_bit_en → one o_cmd_stb, index=0, arg=0, crc_err=0, o_rsp_busy high from transmission bit to strobe.
2. CMD8 arg 0x1AA: frame 48'h48_0000_01AA_87 → index=8, arg=32'h000001AA, crc_err=0. Same frame with CRC byte 0x89 → crc_err=1. Same frame with end bit 0 → crc_err=1.
3. Start bit followed by transmission bit 0 → no o_cmd_stb; a valid CMD17 frame 48'h51_0000_0000_55 sent immediately afterwards → index=17, crc_err=0.
4. R3 response: i_rsp_stb with index 6'h3F, arg 32'h00FF8000, no_crc=1, RSP_GAP=2 → CMD line idle 1 for 2 bit periods, then 48'h3F_00FF_8000_FF captured MSB-first, dir released, one o_rsp_done pulse.
5. R1 response: index 17, arg 32'h00000900, no_crc=0 → captured 48 bits equal {0,0,index,arg,crc7,1}, with crc7 checked against the bench model. A second i_rsp_stb issued mid-transmission is ignored, and only one o_rsp_done pulse occurs.
6. rst asserted at bit 20 of a response and at bit 20 of a command → dir=0 and cmd_out=1 on the next clk, no o_rsp_done and no o_cmd_stb; a subsequent CMD0 is received correctly.

Source files
------------

// File: rtl/sd_dev_cmd_phy.sv
// SD device CMD-line PHY: deserializes 48-bit host commands with CRC7/framing check
// and serializes 48-bit responses after a programmable Ncr gap.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle; waiting for a start bit or a response request
// S_RX_DIR | start bit seen; next bit is the transmission (direction) bit
// S_RX     | shifting in index, argument, CRC7 and end bit (46 bits)
// S_GAP    | Ncr gap before the response; line released and high
// S_TX     | driving the 48-bit response, MSB first
// S_TX_END | end bit driven; release the line on the next bit period
module sd_dev_cmd_phy #(
    parameter int RSP_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bit_en,
    input  logic        i_sd_cmd_in,
    output logic        o_sd_cmd_dir,
    output logic        o_sd_cmd_out,
    output logic        o_cmd_stb,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_cmd_crc_err,
    input  logic        i_rsp_stb,
    input  logic [5:0]  i_rsp_index,
    input  logic [31:0] i_rsp_arg,
    input  logic        i_rsp_no_crc,
    output logic        o_rsp_busy,
    output logic        o_rsp_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_DIR,
        S_RX,
        S_GAP,
        S_TX,
        S_TX_END
    } state_t;

    state_t      r_state;
    logic [5:0]  r_bit_cnt;
    logic [44:0] r_rx_shift;
    logic [6:0]  r_crc;
    logic [39:0] r_tx_shift;
    logic        r_tx_no_crc;
    logic [3:0]  r_gap_cnt;

    logic [45:0] w_rx_frame;
    logic [3:0]  w_gap_load;

    assign w_rx_frame = {r_rx_shift, i_sd_cmd_in};
    assign w_gap_load = 4'(RSP_GAP);

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_crc         <= '0;
            r_tx_shift    <= '0;
            r_tx_no_crc   <= 1'b0;
            r_gap_cnt     <= '0;
            o_sd_cmd_dir  <= 1'b0;
            o_sd_cmd_out  <= 1'b1;
            o_cmd_stb     <= 1'b0;
            o_cmd_index   <= '0;
            o_cmd_arg     <= '0;
            o_cmd_crc_err <= 1'b0;
            o_rsp_busy    <= 1'b0;
            o_rsp_done    <= 1'b0;
        end else begin
            o_cmd_stb  <= 1'b0;
            o_rsp_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A response request wins over a start bit in the same cycle.
                    if (i_rsp_stb) begin
                        r_tx_shift  <= {2'b00, i_rsp_index, i_rsp_arg};
                        r_tx_no_crc <= i_rsp_no_crc;
                        r_gap_cnt   <= w_gap_load;
                        r_crc       <= '0;
                        r_bit_cnt   <= '0;
                        o_rsp_busy  <= 1'b1;
                        r_state     <= S_GAP;
                    end else if (i_bit_en && !i_sd_cmd_in) begin
                        r_crc      <= '0;
                        o_rsp_busy <= 1'b1;
                        r_state    <= S_RX_DIR;
                    end
                end
                S_RX_DIR: begin
                    if (i_bit_en) begin
                        if (i_sd_cmd_in) begin
                            r_crc     <= crc7_step(r_crc, 1'b1);
                            r_bit_cnt <= '0;
                            r_state   <= S_RX;
                        end else begin
                            o_rsp_busy <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_RX: begin
                    if (i_bit_en) begin
                        r_rx_shift <= w_rx_frame[44:0];
                        if (r_bit_cnt < 6'd38)
                            r_crc <= crc7_step(r_crc, i_sd_cmd_in);
                        if (r_bit_cnt == 6'd45) begin
                            o_cmd_stb     <= 1'b1;
                            o_cmd_index   <= w_rx_frame[45:40];
                            o_cmd_arg     <= w_rx_frame[39:8];
                            o_cmd_crc_err <= (w_rx_frame[7:1] != r_crc) | ~i_sd_cmd_in;
                            o_rsp_busy    <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (i_bit_en) begin
                        if (r_gap_cnt == 4'd1)
                            r_state <= S_TX;
                        else
                            r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                S_TX: begin
                    if (i_bit_en) begin
                        o_sd_cmd_dir <= 1'b1;
                        // Bits 0..39 feed the CRC as they go out; 40..46 then shift the CRC out.
                        if (r_bit_cnt < 6'd40) begin
                            o_sd_cmd_out <= r_tx_shift[39];
                            r_tx_shift   <= {r_tx_shift[38:0], 1'b0};
                            r_crc        <= crc7_step(r_crc, r_tx_shift[39]);
                        end else if (r_bit_cnt < 6'd47) begin
                            o_sd_cmd_out <= r_tx_no_crc | r_crc[6];
                            r_crc        <= {r_crc[5:0], 1'b0};
                        end else begin
                            o_sd_cmd_out <= 1'b1;
                        end
                        if (r_bit_cnt == 6'd47)
                            r_state <= S_TX_END;
                        else
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                S_TX_END: begin
                    if (i_bit_en) begin
                        o_sd_cmd_dir <= 1'b0;
                        o_sd_cmd_out <= 1'b1;
                        o_rsp_done   <= 1'b1;
                        o_rsp_busy   <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    o_sd_cmd_dir <= 1'b0;
                    o_sd_cmd_out <= 1'b1;
                    o_rsp_busy   <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dev_cmd_phy.sv
// Directed testbench for sd_dev_cmd_phy: command receive, CRC/framing errors,
// responses with Ncr gap, busy handling and mid-frame reset.
module tb_sd_dev_cmd_phy;

    localparam int GAP = 2;

    logic        clk;
    logic        rst;
    logic        i_bit_en;
    logic        i_sd_cmd_in;
    logic        o_sd_cmd_dir;
    logic        o_sd_cmd_out;
    logic        o_cmd_stb;
    logic [5:0]  o_cmd_index;
    logic [31:0] o_cmd_arg;
    logic        o_cmd_crc_err;
    logic        i_rsp_stb;
    logic [5:0]  i_rsp_index;
    logic [31:0] i_rsp_arg;
    logic        i_rsp_no_crc;
    logic        o_rsp_busy;
    logic        o_rsp_done;

    sd_dev_cmd_phy #(.RSP_GAP(GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_bit_en      (i_bit_en),
        .i_sd_cmd_in   (i_sd_cmd_in),
        .o_sd_cmd_dir  (o_sd_cmd_dir),
        .o_sd_cmd_out  (o_sd_cmd_out),
        .o_cmd_stb     (o_cmd_stb),
        .o_cmd_index   (o_cmd_index),
        .o_cmd_arg     (o_cmd_arg),
        .o_cmd_crc_err (o_cmd_crc_err),
        .i_rsp_stb     (i_rsp_stb),
        .i_rsp_index   (i_rsp_index),
        .i_rsp_arg     (i_rsp_arg),
        .i_rsp_no_crc  (i_rsp_no_crc),
        .o_rsp_busy    (o_rsp_busy),
        .o_rsp_done    (o_rsp_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;
    int stb_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (o_cmd_stb === 1'b1) stb_cnt++;
        if (o_rsp_done === 1'b1) done_cnt++;
    end

    // Outputs sampled on the negedge right after each bit-enable edge.
    logic s_dir, s_out, s_stb, s_busy, s_done;
    logic g_busy_tr, g_stb_end, g_busy_end;
    logic [47:0] g_cap;
    logic g_gap_bad, g_dir_bad;

    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int k = 39; k >= 0; k--) begin
            if (d[k] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    task automatic tick(input logic b);
        i_sd_cmd_in = b;
        i_bit_en    = 1'b1;
        @(negedge clk);
        i_bit_en = 1'b0;
        s_dir  = o_sd_cmd_dir;
        s_out  = o_sd_cmd_out;
        s_stb  = o_cmd_stb;
        s_busy = o_rsp_busy;
        s_done = o_rsp_done;
        repeat (3) @(negedge clk);
        i_sd_cmd_in = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            tick(f[i]);
            if (i == 46) g_busy_tr = s_busy;
        end
        g_stb_end  = s_stb;
        g_busy_end = s_busy;
    endtask

    task automatic request(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc);
        i_rsp_index  = idx;
        i_rsp_arg    = arg;
        i_rsp_no_crc = nocrc;
        i_rsp_stb    = 1'b1;
        @(negedge clk);
        i_rsp_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_rsp(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc,
                           input logic inject);
        request(idx, arg, nocrc);
        g_gap_bad = 1'b0;
        g_dir_bad = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            tick(1'b1);
            if (s_dir !== 1'b0 || s_out !== 1'b1) g_gap_bad = 1'b1;
        end
        for (int i = 47; i >= 0; i--) begin
            tick(1'b1);
            g_cap[i] = s_out;
            if (s_dir !== 1'b1) g_dir_bad = 1'b1;
            if (inject && i == 27) request(6'h05, 32'hDEADBEEF, 1'b0);
        end
        tick(1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (o_sd_cmd_dir !== 1'b0) $display("FAIL reset_dir: got %b want 0", o_sd_cmd_dir); else n_pass++;
        n_chk++; if (o_sd_cmd_out !== 1'b1) $display("FAIL reset_out: got %b want 1", o_sd_cmd_out); else n_pass++;
        n_chk++; if (o_cmd_stb !== 1'b0) $display("FAIL reset_stb: got %b want 0", o_cmd_stb); else n_pass++;
        n_chk++; if (o_cmd_index !== 6'd0) $display("FAIL reset_index: got %h want 0", o_cmd_index); else n_pass++;
        n_chk++; if (o_cmd_arg !== 32'd0) $display("FAIL reset_arg: got %h want 0", o_cmd_arg); else n_pass++;
        n_chk++; if (o_cmd_crc_err !== 1'b0) $display("FAIL reset_crc_err: got %b want 0", o_cmd_crc_err); else n_pass++;
        n_chk++; if (o_rsp_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_rsp_busy); else n_pass++;
        n_chk++; if (o_rsp_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_rsp_done); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd0;
        int base;
        base = stb_cnt;
        send_frame(48'h40_0000_0000_95);
        n_chk++; if (stb_cnt - base !== 1) $display("FAIL cmd0_stb_count: got %0d want 1", stb_cnt - base); else n_pass++;
        n_chk++; if (g_stb_end !== 1'b1) $display("FAIL cmd0_stb_latency: got %b want 1", g_stb_end); else n_pass++;
        n_chk++; if (o_cmd_index !== 6'd0) $display("FAIL cmd0_index: got %h want 0", o_cmd_index); else n_pass++;
        n_chk++; if (o_cmd_arg !== 32'd0) $display("FAIL cmd0_arg: got %h want 0", o_cmd_arg); else n_pass++;
        n_chk++; if (o_cmd_crc_err !== 1'b0) $display("FAIL cmd0_crc_err: got %b want 0", o_cmd_crc_err); else n_pass++;
        n_chk++; if (g_busy_tr !== 1'b1) $display("FAIL cmd0_busy_rx: got %b want 1", g_busy_tr); else n_pass++;
        n_chk++; if (g_busy_end !== 1'b0) $display("FAIL cmd0_busy_end: got %b want 0", g_busy_end); else n_pass++;
    endtask

    task automatic test_cmd8;
        send_frame(48'h48_0000_01AA_87);
        n_chk++; if (o_cmd_index !== 6'd8) $display("FAIL cmd8_index: got %h want 08", o_cmd_index); else n_pass++;
        n_chk++; if (o_cmd_arg !== 32'h000001AA) $display("FAIL cmd8_arg: got %h want 000001aa", o_cmd_arg); else n_pass++;
        n_chk++; if (o_cmd_crc_err !== 1'b0) $display("FAIL cmd8_crc_err: got %b want 0", o_cmd_crc_err); else n_pass++;
        send_frame(48'h48_0000_01AA_89);
        n_chk++; if (o_cmd_crc_err !== 1'b1) $display("FAIL cmd8_bad_crc: got %b want 1", o_cmd_crc_err); else n_pass++;
        send_frame(48'h48_0000_01AA_86);
        n_chk++; if (o_cmd_crc_err !== 1'b1) $display("FAIL cmd8_bad_end: got %b want 1", o_cmd_crc_err); else n_pass++;
        n_chk++; if (o_cmd_index !== 6'd8) $display("FAIL cmd8_bad_end_index: got %h want 08", o_cmd_index); else n_pass++;
    endtask

    task automatic test_abort;
        int base;
        base = stb_cnt;
        tick(1'b0);
        tick(1'b0);
        n_chk++; if (s_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", s_busy); else n_pass++;
        send_frame(48'h51_0000_0000_55);
        n_chk++; if (stb_cnt - base !== 1) $display("FAIL abort_stb_count: got %0d want 1", stb_cnt - base); else n_pass++;
        n_chk++; if (o_cmd_index !== 6'd17) $display("FAIL cmd17_index: got %0d want 17", o_cmd_index); else n_pass++;
        n_chk++; if (o_cmd_crc_err !== 1'b0) $display("FAIL cmd17_crc_err: got %b want 0", o_cmd_crc_err); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int base;
        logic [5:0] idx_first;
        base = stb_cnt;
        send_frame(48'h48_0000_01AA_87);
        idx_first = o_cmd_index;
        send_frame(48'h51_0000_0000_55);
        n_chk++; if (stb_cnt - base !== 2) $display("FAIL b2b_stb_count: got %0d want 2", stb_cnt - base); else n_pass++;
        n_chk++; if (idx_first !== 6'd8) $display("FAIL b2b_first_index: got %0d want 8", idx_first); else n_pass++;
        n_chk++; if (o_cmd_index !== 6'd17) $display("FAIL b2b_second_index: got %0d want 17", o_cmd_index); else n_pass++;
        n_chk++; if (o_cmd_crc_err !== 1'b0) $display("FAIL b2b_crc_err: got %b want 0", o_cmd_crc_err); else n_pass++;
    endtask

    task automatic test_rsp_r3;
        int base;
        base = done_cnt;
        run_rsp(6'h3F, 32'h00FF8000, 1'b1, 1'b0);
        n_chk++; if (g_gap_bad !== 1'b0) $display("FAIL r3_gap_idle: got %b want 0", g_gap_bad); else n_pass++;
        n_chk++; if (g_cap !== 48'h3F_00FF_8000_FF) $display("FAIL r3_frame: got %h want 3f00ff8000ff", g_cap); else n_pass++;
        n_chk++; if (g_dir_bad !== 1'b0) $display("FAIL r3_dir_held: got %b want 0", g_dir_bad); else n_pass++;
        n_chk++; if (s_dir !== 1'b0 || s_out !== 1'b1) $display("FAIL r3_release: got dir=%b out=%b want dir=0 out=1", s_dir, s_out); else n_pass++;
        n_chk++; if (s_done !== 1'b1) $display("FAIL r3_done_timing: got %b want 1", s_done); else n_pass++;
        n_chk++; if (done_cnt - base !== 1) $display("FAIL r3_done_count: got %0d want 1", done_cnt - base); else n_pass++;
    endtask

    task automatic test_rsp_r1;
        int base;
        logic [47:0] exp;
        logic late_dir;
        base = done_cnt;
        exp = {2'b00, 6'd17, 32'h00000900, crc7_model({2'b00, 6'd17, 32'h00000900}), 1'b1};
        run_rsp(6'd17, 32'h00000900, 1'b0, 1'b1);
        n_chk++; if (g_cap !== exp) $display("FAIL r1_frame: got %h want %h", g_cap, exp); else n_pass++;
        n_chk++; if (g_dir_bad !== 1'b0) $display("FAIL r1_dir_held: got %b want 0", g_dir_bad); else n_pass++;
        late_dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            if (s_dir !== 1'b0) late_dir = 1'b1;
        end
        n_chk++; if (late_dir !== 1'b0) $display("FAIL r1_ignored_stb: got dir activity %b want 0", late_dir); else n_pass++;
        n_chk++; if (done_cnt - base !== 1) $display("FAIL r1_done_count: got %0d want 1", done_cnt - base); else n_pass++;
        n_chk++; if (o_rsp_busy !== 1'b0) $display("FAIL r1_busy_after: got %b want 0", o_rsp_busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int dbase;
        int sbase;
        logic [47:0] f;
        dbase = done_cnt;
        request(6'd17, 32'h00000900, 1'b0);
        for (int i = 0; i < GAP + 20; i++) tick(1'b1);
        n_chk++; if (s_dir !== 1'b1) $display("FAIL rstmid_tx_active: got %b want 1", s_dir); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (o_sd_cmd_dir !== 1'b0 || o_sd_cmd_out !== 1'b1) $display("FAIL rstmid_rsp_release: got dir=%b out=%b want dir=0 out=1", o_sd_cmd_dir, o_sd_cmd_out); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1);
        n_chk++; if (done_cnt - dbase !== 0) $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - dbase); else n_pass++;
        sbase = stb_cnt;
        f = 48'h40_0000_0000_95;
        for (int i = 47; i >= 28; i--) tick(f[i]);
        n_chk++; if (s_busy !== 1'b1) $display("FAIL rstmid_rx_active: got %b want 1", s_busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (o_rsp_busy !== 1'b0) $display("FAIL rstmid_cmd_busy: got %b want 0", o_rsp_busy); else n_pass++;
        for (int i = 0; i < 4; i++) tick(1'b1);
        n_chk++; if (stb_cnt - sbase !== 0) $display("FAIL rstmid_no_stb: got %0d want 0", stb_cnt - sbase); else n_pass++;
        send_frame(48'h40_0000_0000_95);
        n_chk++; if (stb_cnt - sbase !== 1) $display("FAIL rstmid_cmd0_stb: got %0d want 1", stb_cnt - sbase); else n_pass++;
        n_chk++; if (o_cmd_index !== 6'd0 || o_cmd_crc_err !== 1'b0) $display("FAIL rstmid_cmd0: got idx=%0d err=%b want idx=0 err=0", o_cmd_index, o_cmd_crc_err); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        i_bit_en     = 1'b0;
        i_sd_cmd_in  = 1'b1;
        i_rsp_stb    = 1'b0;
        i_rsp_index  = 6'd0;
        i_rsp_arg    = 32'd0;
        i_rsp_no_crc = 1'b0;
        @(negedge clk);
        test_reset;
        test_cmd0;
        test_cmd8;
        test_abort;
        test_back_to_back;
        test_rsp_r3;
        test_rsp_r1;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
